// File: rtl/aes_cmd_master.sv
// Memory-side bus initiator for the AES block: key/text load, hash, result
// readback and ack handshake, with a per-wait stall timeout.
module aes_cmd_master #(
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [1:0]  AES_ID  = 2'b10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key_in,
    input  logic [127:0] text_in,
    input  logic [23:0]  addr_in,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [127:0] result,
    output logic [7:0]   bus_data,
    output logic         bus_valid,
    input  logic         bus_ready,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    input  logic         ack_valid,
    output logic         ack_ready,
    input  logic [1:0]   ack_src
);

    localparam logic [1:0]  MEM_ID    = 2'b00;
    localparam logic [15:0] STALL_MAX = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_RX, S_ACK, S_DONE} state_t;
    typedef enum logic [1:0] {PH_KEY, PH_TEXT, PH_HASH, PH_WRITE} phase_t;

    state_t         state_q, state_d;
    phase_t         phase_q, phase_d;
    logic [5:0]     beat_q, beat_d;
    logic [15:0]    stall_q, stall_d;
    logic [255:0]   shift_q, shift_d;
    logic [127:0]   text_q, text_d;
    logic [23:0]    addr_q, addr_d;
    logic [127:0]   result_q, result_d;
    logic           error_q, error_d;
    logic [7:0]     hdr_byte;
    logic [5:0]     pay_last;
    logic           stall_hit;

    assign stall_hit = (stall_q == STALL_MAX);
    assign pay_last  = (phase_q == PH_KEY) ? 6'd31 : 6'd15;

    always_comb begin
        hdr_byte = '0;
        case (phase_q)
            PH_KEY:   hdr_byte = {2'b00, AES_ID, MEM_ID, 2'b00};
            PH_TEXT:  hdr_byte = {2'b00, AES_ID, MEM_ID, 2'b01};
            PH_HASH:  hdr_byte = {2'b00, AES_ID, MEM_ID, 2'b11};
            PH_WRITE: hdr_byte = {2'b00, MEM_ID, AES_ID, 2'b10};
            default:  hdr_byte = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        beat_d    = beat_q;
        stall_d   = stall_q;
        shift_d   = shift_q;
        text_d    = text_q;
        addr_d    = addr_q;
        result_d  = result_q;
        error_d   = error_q;
        bus_valid = 1'b0;
        bus_data  = '0;
        rx_ready  = 1'b0;
        ack_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = key_in;
                    text_d  = text_in;
                    addr_d  = addr_in;
                    error_d = 1'b0;
                    phase_d = PH_KEY;
                    beat_d  = '0;
                    stall_d = '0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                bus_valid = 1'b1;
                case (beat_q[1:0])
                    2'd0:    bus_data = hdr_byte;
                    2'd1:    bus_data = addr_q[23:16];
                    2'd2:    bus_data = addr_q[15:8];
                    default: bus_data = addr_q[7:0];
                endcase
                if (bus_ready) begin
                    stall_d = '0;
                    if (beat_q == 6'd3) begin
                        beat_d = '0;
                        case (phase_q)
                            PH_HASH:  phase_d = PH_WRITE;
                            PH_WRITE: state_d = S_RX;
                            default:  state_d = S_PAYLOAD;
                        endcase
                    end else begin
                        beat_d = beat_q + 6'd1;
                    end
                end else if (stall_hit) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end
            S_PAYLOAD: begin
                bus_valid = 1'b1;
                bus_data  = shift_q[255:248];
                if (bus_ready) begin
                    stall_d = '0;
                    shift_d = {shift_q[247:0], 8'h00};
                    if (beat_q == pay_last) begin
                        beat_d  = '0;
                        state_d = S_HDR;
                        // Key shifter is reused for the plaintext once the key is out.
                        if (phase_q == PH_KEY) begin
                            phase_d = PH_TEXT;
                            shift_d = {text_q, 128'h0};
                        end else begin
                            phase_d = PH_HASH;
                        end
                    end else begin
                        beat_d = beat_q + 6'd1;
                    end
                end else if (stall_hit) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end
            S_RX: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    stall_d  = '0;
                    result_d = {result_q[119:0], rx_data};
                    if (beat_q == 6'd15) begin
                        beat_d  = '0;
                        state_d = S_ACK;
                    end else begin
                        beat_d = beat_q + 6'd1;
                    end
                end else if (stall_hit) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end
            S_ACK: begin
                ack_ready = 1'b1;
                if (ack_valid) begin
                    stall_d = '0;
                    if (ack_src == AES_ID) state_d = S_DONE;
                end else if (stall_hit) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_KEY;
            beat_q   <= '0;
            stall_q  <= '0;
            shift_q  <= '0;
            text_q   <= '0;
            addr_q   <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            beat_q   <= beat_d;
            stall_q  <= stall_d;
            shift_q  <= shift_d;
            text_q   <= text_d;
            addr_q   <= addr_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done   = (state_q == S_DONE);
    assign error  = error_q;
    assign result = result_q;

endmodule

// File: tb/tb_aes_cmd_master.sv
// Scoreboard bench for aes_cmd_master with a behavioural AES bus partner.
module tb_aes_cmd_master;

    localparam int unsigned TO = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [255:0] key_in = '0;
    logic [127:0] text_in = '0;
    logic [23:0]  addr_in = '0;
    logic         busy, done, error;
    logic [127:0] result;
    logic [7:0]   bus_data;
    logic         bus_valid;
    logic         bus_ready = 1'b0;
    logic [7:0]   rx_data = '0;
    logic         rx_valid = 1'b0;
    logic         rx_ready;
    logic         ack_valid = 1'b0;
    logic         ack_ready;
    logic [1:0]   ack_src = '0;

    always #5 clk = ~clk;

    aes_cmd_master #(.TIMEOUT(TO), .AES_ID(2'b10)) dut (
        .clk(clk), .rst(rst), .start(start),
        .key_in(key_in), .text_in(text_in), .addr_in(addr_in),
        .busy(busy), .done(done), .error(error), .result(result),
        .bus_data(bus_data), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .ack_valid(ack_valid), .ack_ready(ack_ready), .ack_src(ack_src)
    );

    typedef struct {
        logic         err;
        logic [127:0] res;
    } done_t;

    int unsigned  total = 0, bad = 0;
    logic [7:0]   exp_beats[$];
    done_t        exp_done[$];

    logic [255:0] KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    logic [127:0] TEXT = 128'h00112233445566778899aabbccddeeff;
    logic [23:0]  ADDR = 24'h123456;
    logic [127:0] CT   = 128'h8ea2b7ca516745bfeafc49904b496089;

    // partner modes, owned by the stimulus process
    bit rand_bp = 0, hang_after_hash = 0, allow_abort = 0;
    int wrong_ack_n = 0, wr_stall_n = 8;

    // transaction counters, owned by the monitor
    int  beats_done = 0, rx_taken = 0, ack_wrong = 0, done_cnt = 0;
    int  cyc = 0, beat56_cyc = 0, done_cyc = 0;
    bit  ack_taken = 0, prev_stall = 0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [255:0] k, input logic [127:0] t, input logic [23:0] a,
                            input logic err);
        logic [7:0] hdrs [4];
        done_t d;
        hdrs = '{8'h20, 8'h21, 8'h23, 8'h0A};
        for (int p = 0; p < 4; p++) begin
            exp_beats.push_back(hdrs[p]);
            exp_beats.push_back(a[23:16]);
            exp_beats.push_back(a[15:8]);
            exp_beats.push_back(a[7:0]);
            if (p == 0) for (int i = 0; i < 32; i++) exp_beats.push_back(k[255-8*i -: 8]);
            if (p == 1) for (int i = 0; i < 16; i++) exp_beats.push_back(t[127-8*i -: 8]);
        end
        d.err = err;
        d.res = CT;
        exp_done.push_back(d);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n0;
        bit seen;
        n0 = done_cnt;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (done_cnt != n0) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic check_single_done(input string name);
        int n0;
        n0 = done_cnt;
        repeat (6) @(posedge clk);
        #1;
        chk(name, done_cnt, n0);
    endtask

    // Monitor: pops the scoreboard on every beat and every done pulse.
    always @(negedge clk) begin
        done_t e;
        cyc++;
        if (rst) begin
            beats_done = 0; rx_taken = 0; ack_wrong = 0; ack_taken = 0; prev_stall = 0;
        end else begin
            if (start && !busy && !done) begin
                beats_done = 0; rx_taken = 0; ack_wrong = 0; ack_taken = 0;
            end
            if (prev_stall) begin
                if (bus_valid) chk("hold_data", bus_data, prev_data);
                else if (!allow_abort) chk("hold_valid", bus_valid, 1'b1);
            end
            prev_stall = bus_valid && !bus_ready;
            prev_data  = bus_data;
            if (bus_valid && bus_ready) begin
                if (exp_beats.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_beat: got %h want none", bus_data);
                end else begin
                    chk("beat", bus_data, exp_beats.pop_front());
                end
                beats_done++;
                if (beats_done == 56) beat56_cyc = cyc;
            end
            if (rx_valid && rx_ready) rx_taken++;
            if (ack_valid && ack_ready) begin
                if (ack_src == 2'b10) ack_taken = 1;
                else ack_wrong++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_done.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done want none");
                end else begin
                    e = exp_done.pop_front();
                    chk("error", error, e.err);
                    if (!e.err) begin
                        chk("result", result, e.res);
                        chk("beat_count", beats_done, 64);
                    end
                    chk("busy_at_done", busy, 1'b0);
                end
            end
        end
    end

    // AES partner: drives ready/rx/ack just after each rising edge.
    int wr_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (beats_done < 60) wr_cnt = 0;
        if (hang_after_hash && beats_done >= 56) bus_ready = 1'b0;
        else if (beats_done == 60 && wr_cnt < wr_stall_n) begin
            bus_ready = 1'b0;
            wr_cnt++;
        end else if (rand_bp) bus_ready = ($urandom_range(0, 2) != 0);
        else bus_ready = 1'b1;
        rx_valid = (beats_done == 64) && (rx_taken < 16) && (!rand_bp || $urandom_range(0, 3) != 0);
        rx_data  = (rx_taken < 16) ? CT[8*(15-rx_taken) +: 8] : 8'hA5;
        ack_valid = (rx_taken == 16) && !ack_taken;
        ack_src   = (ack_wrong < wrong_ack_n) ? 2'b01 : 2'b10;
    end

    initial begin
        key_in = KEY; text_in = TEXT; addr_in = ADDR;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_result", result, 128'h0);
        chk("rst_bus_valid", bus_valid, 1'b0);
        chk("rst_bus_data", bus_data, 8'h00);
        chk("rst_rx_ready", rx_ready, 1'b0);
        chk("rst_ack_ready", ack_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // happy path
        push_seq(KEY, TEXT, ADDR, 1'b0);
        pulse_start();
        chk("busy_after_start", busy, 1'b1);
        wait_done(400, "happy_done");
        check_single_done("happy_one_done");

        // random backpressure plus an ignored start while busy
        rand_bp = 1;
        push_seq(KEY, TEXT, ADDR, 1'b0);
        pulse_start();
        for (int i = 0; i < 200 && beats_done < 5; i++) begin
            @(posedge clk); #1;
        end
        key_in = ~KEY;
        pulse_start();
        key_in = KEY;
        wait_done(2000, "bp_done");
        check_single_done("bp_one_done");
        rand_bp = 0;

        // wrong ack source for 5 cycles
        wrong_ack_n = 5;
        push_seq(KEY, TEXT, ADDR, 1'b0);
        pulse_start();
        wait_done(400, "ack_done");
        chk("wrong_ack_cycles", ack_wrong, 5);
        wrong_ack_n = 0;

        // timeout after HASH header
        hang_after_hash = 1;
        allow_abort = 1;
        push_seq(KEY, TEXT, ADDR, 1'b1);
        pulse_start();
        wait_done(TO + 200, "timeout_done");
        chk("timeout_cycles_ok", (done_cyc - beat56_cyc >= int'(TO)) &&
                                 (done_cyc - beat56_cyc <= int'(TO) + 2), 1'b1);
        chk("to_error", error, 1'b1);
        chk("to_bus_valid", bus_valid, 1'b0);
        chk("to_bus_data", bus_data, 8'h00);
        chk("to_rx_ready", rx_ready, 1'b0);
        chk("to_ack_ready", ack_ready, 1'b0);
        chk("to_leftover_beats", exp_beats.size(), 8);
        exp_beats.delete();
        hang_after_hash = 0;
        allow_abort = 0;

        // next start clears error; reset mid-sequence, then full restart
        push_seq(KEY, TEXT, ADDR, 1'b0);
        pulse_start();
        @(posedge clk); #1;
        chk("error_cleared", error, 1'b0);
        for (int i = 0; i < 200 && beats_done < 10; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        exp_beats.delete();
        exp_done.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_bus_valid", bus_valid, 1'b0);
        push_seq(KEY, TEXT, ADDR, 1'b0);
        pulse_start();
        wait_done(400, "restart_done");
        check_single_done("restart_one_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_cmd_master.md
Name: aes_cmd_master

Overview:
- Bus initiator that drives the AES accelerator's byte data bus and ack bus from the memory side (MEM_ID = 2'b00).
- On a start pulse it runs one full command sequence:
  - LOAD_KEY with 32 key bytes,
  - LOAD_TEXT with 16 plaintext bytes,
  - HASH,
  - WRITE_RESULT, after which it collects 16 ciphertext bytes.
- It then completes the ack handshake and presents the 128-bit result to the host logic.
- It sits between the SoC sequencer/memory model and the aes block.

Parameters:
- TIMEOUT, 1024: max consecutive stall cycles in any wait before abort; 16-bit counter.
- AES_ID, 2'b10: expected module_source_id on ack and dest/source field value.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; ignored while busy
- key_in  in  256  AES-256 key, byte 0 = key_in[255:248]; sampled at start
- text_in  in  128  plaintext, MSB-first; sampled at start
- addr_in  in  24  address sent in the 3 addr beats of every header, MSB byte first; sampled at start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at sequence end (success or abort)
- error  out  1  set with done on timeout; held until next accepted start
- result  out  128  ciphertext, first received byte in [127:120]; valid when done && !error, held until next start
- bus_data  out  8  byte to aes data_in
- bus_valid  out  1  to aes valid_in
- bus_ready  in  1  from aes ready_in
- rx_data  in  8  from aes data_out
- rx_valid  in  1  from aes data_valid
- rx_ready  out  1  to aes data_ready
- ack_valid  in  1  from aes ack_valid
- ack_ready  out  1  to aes ack_ready
- ack_src  in  2  from aes module_source_id

Behaviour:
- Reset: all registers and outputs are 0 (bus_valid, rx_ready, ack_ready, busy, done, error, result, bus_data). FSM goes to IDLE. Reset mid-sequence abandons it with no done pulse.
- Beat transfer: a beat transfers when bus_valid && bus_ready at a rising edge.
  - bus_data must stay stable while bus_valid is high and bus_ready is low.
  - The next beat may follow back-to-back, with no bubble required.
- Header byte is {2'b00, dest[1:0], src[1:0], op[1:0]}:
  - LOAD_KEY = 8'h20
  - LOAD_TEXT = 8'h21
  - HASH = 8'h23
  - WRITE_RESULT = 8'h0A (src = AES, dest = MEM)
- Every header is followed by addr_in[23:16], [15:8], [7:0].
- Phases, in order:
  - KEY: 4 header beats + 32 key bytes
  - TEXT: 4 + 16
  - HASH: 4
  - WRITE: 4
- Total is 64 transmit beats. HASH has no payload.
- The WRITE header stalls naturally while the AES core is computing (ready low); the master just waits.
- FSM states:
  - IDLE: on start, latch key, text and addr, clear error; go to HDR (phase = KEY, beat_cnt = 0).
  - HDR: send 4 beats. After beat 3:
    - KEY/TEXT → PAYLOAD
    - HASH → HDR (phase = WRITE)
    - WRITE → RX
  - PAYLOAD: send 32 (KEY) or 16 (TEXT) bytes, MSB-first from a shift register. After the last byte → HDR with the next phase.
  - RX: rx_ready = 1. Each cycle with rx_valid, shift rx_data into result from the LSB end, so the first byte ends in [127:120]. After the 16th byte → ACK.
  - ACK: ack_ready = 1. When ack_valid && ack_src == AES_ID → DONE. If ack_valid has a wrong ack_src, keep waiting.
  - DONE: pulse done for 1 cycle, drop busy, → IDLE.
- rx_valid outside RX is ignored; result is not modified.
- rx_ready and ack_ready are 0 outside their states.
- Timeout:
  - The stall counter resets on every transferred beat, received byte or ack.
  - It increments in HDR/PAYLOAD while bus_ready is low, in RX while rx_valid is low, and in ACK while ack_valid is low.
  - When it reaches TIMEOUT: deassert bus_valid, rx_ready and ack_ready; set error; → DONE.
- start and done in the same cycle: start is ignored, because the master is still busy until IDLE.

Test Plan:
- Back-to-back happy path, with the aes block as the DUT partner:
  - Stimulus: key = 00..1f, text = 00112233445566778899aabbccddeeff, addr = 0x123456.
  - Required: result = 8ea2b7ca516745bfeafc49904b496089, error = 0, exactly 64 transmit beats, one done pulse.
- Beat ordering: the first transmitted beats are 20,12,34,56,00,01; the TEXT header is 21,12,34,56; then 23,… and 0A,….
- Backpressure: with random bus_ready deassertion, bus_data/bus_valid hold steady while stalled and the result is unchanged.
- Wrong ack source: ack_valid with ack_src = 2'b01 for 5 cycles, then 2'b10 → done fires only after the correct source.
- Timeout: bus_ready held low after the HASH header → done with error = 1 after TIMEOUT cycles, then all bus outputs are 0; the next start clears error.
- Reset after beat 10, followed by a start → the full sequence restarts from header 8'h20 and completes correctly.
